// File: rtl/exc_commit_ctrl.sv
// Dual-issue commit-stage exception controller: interrupt masking, per-slot exception
// prioritisation, CP0 excepttype codes, and flush/drain/redirect sequencing. Optional: INT_SYNC_EN.
module exc_commit_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          DRAIN_MAX  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_w,
    input  logic        valid1_i,
    input  logic        valid2_i,
    input  logic [7:0]  excflags1_i,
    input  logic [7:0]  excflags2_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [5:0]  int_i,
    input  logic        mem_busy_i,
    output logic [31:0] excepttype1_o,
    output logic [31:0] excepttype2_o,
    output logic        kill2_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    localparam int             CW       = $clog2(DRAIN_MAX) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DRAIN_MAX - 1);
    localparam logic [CW-1:0]  CNT_SAT  = {CW{1'b1}};
    localparam logic [7:0]     CODE_INT = 8'h01;
    localparam logic [7:0]     CODE_ERET = 8'h0e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  drain_cnt;
    logic [5:0]     int_s;
    logic           int_pend;
    logic           commit;
    logic [7:0]     code1;
    logic [7:0]     code2;
    logic [7:0]     take_code;
    logic           take;
    logic [31:0]    target;

    logic unused_bits;
    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

`ifdef INT_SYNC_EN
    logic [5:0] int_meta;
    logic [5:0] int_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            int_meta <= '0;
            int_sync <= '0;
        end else begin
            int_meta <= int_i;
            int_sync <= int_meta;
        end
    end

    assign int_s = int_sync;
`else
    assign int_s = int_i;
`endif

    assign int_pend = status_i[0] & ~status_i[1]
                    & (|(status_i[15:8] & {int_s, cause_i[9:8]}));

    // Later assignments override earlier ones, so the list runs lowest priority first.
    function automatic logic [7:0] flag_code(input logic [7:0] f);
        logic [7:0] c;
        c = 8'h00;
        if (f[7]) c = 8'h0e;
        if (f[6]) c = 8'h05;
        if (f[5]) c = 8'h04;
        if (f[4]) c = 8'h09;
        if (f[3]) c = 8'h08;
        if (f[2]) c = 8'h0c;
        if (f[1]) c = 8'h0a;
        if (f[0]) c = 8'h04;
        return c;
    endfunction

    assign commit = (state == IDLE) & ~stall_w & ~rst;

    // The interrupt rides on the oldest valid slot; with no valid slot it waits.
    always_comb begin
        code1 = 8'h00;
        code2 = 8'h00;
        if (valid1_i) begin
            code1 = int_pend ? CODE_INT : flag_code(excflags1_i);
        end
        if (valid2_i) begin
            code2 = (int_pend & ~valid1_i) ? CODE_INT : flag_code(excflags2_i);
        end
    end

    assign take_code = (code1 != 8'h00) ? code1 : code2;
    assign take      = commit & (take_code != 8'h00);
    assign target    = (take_code == CODE_ERET) ? epc_i : EXC_VECTOR;

    always_comb begin
        state_next    = state;
        excepttype1_o = 32'h0;
        excepttype2_o = 32'h0;
        kill2_o       = 1'b0;
        flush_o       = 1'b0;
        redirect_o    = 1'b0;
        busy_o        = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    excepttype1_o = {24'h0, code1};
                    excepttype2_o = (code1 != 8'h00) ? 32'h0 : {24'h0, code2};
                    kill2_o       = (code1 != 8'h00);
                end
                if (take) begin
                    flush_o    = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                flush_o = 1'b1;
                busy_o  = 1'b1;
                if (~mem_busy_i || (drain_cnt == CNT_LAST)) begin
                    state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                flush_o    = 1'b1;
                busy_o     = 1'b1;
                redirect_o = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            redirect_pc_o <= 32'h0;
        end else begin
            state <= state_next;
            if (take) begin
                drain_cnt     <= '0;
                redirect_pc_o <= target;
            end else if ((state == DRAIN) && (drain_cnt != CNT_SAT)) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed scenarios then random traffic,
// all compared against a cycle-age reference model of the exception sequence.
module tb_exc_commit_ctrl;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
    localparam int          DRAIN_MAX  = 16;
    localparam logic [7:0]  CODE_TAB [8] = '{8'h04, 8'h0a, 8'h0c, 8'h08, 8'h09, 8'h04, 8'h05, 8'h0e};

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_w;
    logic        valid1_i;
    logic        valid2_i;
    logic [7:0]  excflags1_i;
    logic [7:0]  excflags2_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic [5:0]  int_i;
    logic        mem_busy_i;
    logic [31:0] excepttype1_o;
    logic [31:0] excepttype2_o;
    logic        kill2_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    exc_commit_ctrl #(
        .EXC_VECTOR(EXC_VECTOR),
        .DRAIN_MAX (DRAIN_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_w      (stall_w),
        .valid1_i     (valid1_i),
        .valid2_i     (valid2_i),
        .excflags1_i  (excflags1_i),
        .excflags2_i  (excflags2_i),
        .status_i     (status_i),
        .cause_i      (cause_i),
        .epc_i        (epc_i),
        .int_i        (int_i),
        .mem_busy_i   (mem_busy_i),
        .excepttype1_o(excepttype1_o),
        .excepttype2_o(excepttype2_o),
        .kill2_o      (kill2_o),
        .flush_o      (flush_o),
        .redirect_o   (redirect_o),
        .redirect_pc_o(redirect_pc_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Reference model: age of the current cycle since the accepted commit (-1 = idle).
    int          m_age       = -1;
    int          m_redir_age = 1000;
    logic [31:0] m_pc        = 32'h0;
    logic [5:0]  m_sync1     = 6'h0;
    logic [5:0]  m_sync2     = 6'h0;
    logic [7:0]  e_take_code;
    logic [31:0] e_target;
    logic        obs_redirect;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] top_code(input logic [7:0] f);
        for (int b = 0; b < 8; b++) begin
            if (f[b]) return CODE_TAB[b];
        end
        return 8'h00;
    endfunction

    function automatic bit int_pending(input logic [31:0] st, input logic [31:0] cs, input logic [5:0] is);
        logic [7:0] lines;
        lines = {is, cs[9:8]};
        if (!st[0] || st[1]) return 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (st[8+b] && lines[b]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_cycle();
        bit          idle;
        bit          commit;
        bit          pend;
        logic [5:0]  is;
        logic [7:0]  c1;
        logic [7:0]  c2;
        logic [31:0] x1;
        logic [31:0] x2;
        bit          exp_redir;
`ifdef INT_SYNC_EN
        is = m_sync2;
`else
        is = int_i;
`endif
        idle   = (m_age < 0);
        commit = idle && !stall_w && !rst;
        pend   = int_pending(status_i, cause_i, is);
        c1 = valid1_i ? (pend ? 8'h01 : top_code(excflags1_i)) : 8'h00;
        c2 = valid2_i ? ((pend && !valid1_i) ? 8'h01 : top_code(excflags2_i)) : 8'h00;
        x1 = commit ? {24'h0, c1} : 32'h0;
        x2 = (commit && c1 == 8'h00) ? {24'h0, c2} : 32'h0;
        e_take_code = commit ? ((c1 != 8'h00) ? c1 : c2) : 8'h00;
        e_target    = (e_take_code == 8'h0e) ? epc_i : EXC_VECTOR;
        exp_redir   = !idle && (m_age == m_redir_age);
        obs_redirect = redirect_o;
        check_val("excepttype1", excepttype1_o, x1);
        check_val("excepttype2", excepttype2_o, x2);
        check_val("kill2", {31'h0, kill2_o}, {31'h0, commit && c1 != 8'h00});
        check_val("flush", {31'h0, flush_o}, {31'h0, !idle || e_take_code != 8'h00});
        check_val("redirect", {31'h0, redirect_o}, {31'h0, exp_redir});
        check_val("busy", {31'h0, busy_o}, {31'h0, !idle});
        if (exp_redir) check_val("redirect_pc", redirect_pc_o, m_pc);
    endtask

    task automatic model_edge();
        if (rst) begin
            m_age       = -1;
            m_redir_age = 1000;
            m_pc        = 32'h0;
            m_sync1     = 6'h0;
            m_sync2     = 6'h0;
        end else begin
            m_sync2 = m_sync1;
            m_sync1 = int_i;
            if (m_age < 0) begin
                if (e_take_code != 8'h00) begin
                    m_age       = 1;
                    m_redir_age = 1000;
                    m_pc        = e_target;
                end
            end else if (m_age == m_redir_age) begin
                m_age = -1;
            end else begin
                if (!mem_busy_i || m_age == DRAIN_MAX) m_redir_age = m_age + 1;
                m_age++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_slots();
        valid1_i    = 1'b0;
        valid2_i    = 1'b0;
        excflags1_i = 8'h00;
        excflags2_i = 8'h00;
        int_i       = 6'h0;
    endtask

    int redir_idx;

    initial begin
        rst        = 1'b1;
        stall_w    = 1'b0;
        status_i   = 32'h0;
        cause_i    = 32'h0;
        epc_i      = 32'h0;
        mem_busy_i = 1'b0;
        clear_slots();
        @(posedge clk);
        #1;
        repeat (2) step();
        check_val("reset_pc", redirect_pc_o, 32'h0);
        rst = 1'b0;
        step();

        // ov in slot1 with slot2 also valid
        valid1_i = 1'b1; excflags1_i = 8'h04; valid2_i = 1'b1; excflags2_i = 8'h08;
        step();
        clear_slots();
        repeat (4) step();

        // sys in slot2 passes through
        valid1_i = 1'b1; valid2_i = 1'b1; excflags2_i = 8'h08;
        step();
        clear_slots();
        repeat (4) step();

        // interrupt beats ri, then masked by EXL
        status_i = 32'h0000_0401;
        valid1_i = 1'b1; excflags1_i = 8'h02; int_i = 6'b000001;
        step();
        clear_slots();
        repeat (4) step();
        status_i = 32'h0000_0403;
        valid1_i = 1'b1; excflags1_i = 8'h02; int_i = 6'b000001;
        step();
        clear_slots();
        repeat (4) step();
        status_i = 32'h0;

        // eret with memory busy for the first DRAIN cycles
        epc_i = 32'h8000_1234; mem_busy_i = 1'b1;
        valid1_i = 1'b1; excflags1_i = 8'h80;
        step();
        clear_slots();
        repeat (4) step();
        mem_busy_i = 1'b0;
        repeat (4) step();

        // drain timeout with memory stuck busy
        mem_busy_i = 1'b1;
        valid1_i = 1'b1; excflags1_i = 8'h04;
        redir_idx = -1;
        for (int i = 0; i < 22; i++) begin
            step();
            if (obs_redirect && redir_idx < 0) redir_idx = i;
            clear_slots();
        end
        check_val("timeout_redirect_idx", redir_idx, DRAIN_MAX + 1);

        // reset while draining aborts the redirect
        valid1_i = 1'b1; excflags1_i = 8'h10;
        step();
        clear_slots();
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_busy_i = 1'b0;
        repeat (6) step();

        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            stall_w     = ($urandom_range(0, 3) == 0);
            valid1_i    = $urandom_range(0, 1) == 1;
            valid2_i    = $urandom_range(0, 1) == 1;
            excflags1_i = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            excflags2_i = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            status_i    = $urandom;
            cause_i     = $urandom;
            epc_i       = $urandom;
            int_i       = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
            mem_busy_i  = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0;
        clear_slots();
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
